interval_irq_ctrl: RTL and testbench

Consumer side of the interval timer's interrupt output. It turns each rising edge of the timer interrupt into a sticky, level-type request toward the host, holds that request until the host acknowledges it, and counts delivered and missed (overrun) ticks. It sits between `interval_timer` and the host interrupt/register interface in the ICS interface subsystem.

---
 rtl/interval_irq_ctrl.sv | 88 ++++++++
 tb/tb_interval_irq_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/interval_irq_ctrl.sv
// rtl/interval_irq_ctrl.sv - sticky level interrupt request from interval timer ticks, with tick/overrun counters
module interval_irq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic             ack_i,
    input  logic             clear_cnt_i,
    output logic             irq_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] tick_cnt_o,
    output logic [CNT_W-1:0] overrun_cnt_o
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_WAIT     = 2'd1,
        ST_PEND     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state, state_nxt;
    logic   tick_d;
    logic   rise;
    logic   accept;
    logic   overrun_evt;

    assign rise = tick_i & ~tick_d;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        overrun_evt = 1'b0;
        case (state)
            ST_DISABLED: begin
                if (enable_i) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rise) begin
                    state_nxt = ST_PEND;
                    accept    = 1'b1;
                end
            end
            ST_PEND: begin
                // A rise coinciding with ack replaces the acknowledged request.
                if (rise && ack_i)  accept      = 1'b1;
                else if (rise)      overrun_evt = 1'b1;
                else if (ack_i)     state_nxt   = ST_WAIT;
            end
            default: state_nxt = ST_DISABLED;
        endcase
        if (!enable_i) begin
            state_nxt   = ST_DISABLED;
            accept      = 1'b0;
            overrun_evt = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= ST_DISABLED;
            tick_d        <= 1'b0;
            overrun_o     <= 1'b0;
            tick_cnt_o    <= '0;
            overrun_cnt_o <= '0;
        end else begin
            state  <= state_nxt;
            tick_d <= tick_i;
            if (overrun_evt)  overrun_o <= 1'b1;
            else if (ack_i)   overrun_o <= 1'b0;
            if (clear_cnt_i) begin
                tick_cnt_o    <= '0;
                overrun_cnt_o <= '0;
            end else begin
                if (accept) tick_cnt_o <= tick_cnt_o + CNT_ONE;
                if (overrun_evt && overrun_cnt_o != CNT_MAX)
                    overrun_cnt_o <= overrun_cnt_o + CNT_ONE;
            end
        end
    end

    assign irq_o = (state == ST_PEND);

endmodule

// File: tb/tb_interval_irq_ctrl.sv
// tb/tb_interval_irq_ctrl.sv - directed vector bench for interval_irq_ctrl
module tb_interval_irq_ctrl;

    logic ap_clk = 1'b0;
    logic ap_rst, tick_i, enable_i, ack_i, clear_cnt_i;
    logic irq16, ovr16, irq4, ovr4;
    logic [15:0] tcnt16, ocnt16;
    logic [3:0]  tcnt4, ocnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    interval_irq_ctrl #(.CNT_W(16)) dut16 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .tick_i(tick_i), .enable_i(enable_i),
        .ack_i(ack_i), .clear_cnt_i(clear_cnt_i), .irq_o(irq16), .overrun_o(ovr16),
        .tick_cnt_o(tcnt16), .overrun_cnt_o(ocnt16)
    );

    interval_irq_ctrl #(.CNT_W(4)) dut4 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .tick_i(tick_i), .enable_i(enable_i),
        .ack_i(ack_i), .clear_cnt_i(clear_cnt_i), .irq_o(irq4), .overrun_o(ovr4),
        .tick_cnt_o(tcnt4), .overrun_cnt_o(ocnt4)
    );

    typedef struct {
        logic tick, en, ack, clr;
        logic irq, ovr;
        int   tcnt, ocnt;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic t, input logic e, input logic a, input logic c);
        @(negedge ap_clk);
        ap_rst = r; tick_i = t; enable_i = e; ack_i = a; clear_cnt_i = c;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic irq, input logic ovr,
                             input int tc16, input int oc16, input int tc4, input int oc4);
        chk({tag, " irq16"}, int'(irq16), int'(irq));
        chk({tag, " ovr16"}, int'(ovr16), int'(ovr));
        chk({tag, " tcnt16"}, int'(tcnt16), tc16);
        chk({tag, " ocnt16"}, int'(ocnt16), oc16);
        chk({tag, " irq4"}, int'(irq4), int'(irq));
        chk({tag, " tcnt4"}, int'(tcnt4), tc4);
        chk({tag, " ocnt4"}, int'(ocnt4), oc4);
    endtask

    task automatic setv(input int i, input logic t, input logic e, input logic a, input logic c,
                        input logic irq, input logic ovr, input int tc, input int oc);
        vecs[i].tick = t; vecs[i].en = e; vecs[i].ack = a; vecs[i].clr = c;
        vecs[i].irq = irq; vecs[i].ovr = ovr; vecs[i].tcnt = tc; vecs[i].ocnt = oc;
    endtask

    initial begin
        ap_rst = 1'b1; tick_i = 1'b0; enable_i = 1'b0; ack_i = 1'b0; clear_cnt_i = 1'b0;

        //        i  tick en ack clr  irq ovr tcnt ocnt
        setv( 0, 0, 1, 0, 0, 0, 0, 0, 0);
        setv( 1, 1, 1, 0, 0, 1, 0, 1, 0);
        setv( 2, 0, 1, 0, 0, 1, 0, 1, 0);
        setv( 3, 0, 1, 0, 0, 1, 0, 1, 0);
        setv( 4, 0, 1, 1, 0, 0, 0, 1, 0);
        setv( 5, 1, 1, 0, 0, 1, 0, 2, 0);
        setv( 6, 0, 1, 0, 0, 1, 0, 2, 0);
        setv( 7, 1, 1, 0, 0, 1, 1, 2, 1);
        setv( 8, 0, 1, 0, 0, 1, 1, 2, 1);
        setv( 9, 1, 1, 0, 0, 1, 1, 2, 2);
        setv(10, 0, 1, 1, 0, 0, 0, 2, 2);
        setv(11, 1, 1, 0, 0, 1, 0, 3, 2);
        setv(12, 0, 1, 0, 0, 1, 0, 3, 2);
        setv(13, 1, 1, 1, 0, 1, 0, 4, 2);
        setv(14, 0, 1, 0, 0, 1, 0, 4, 2);
        setv(15, 1, 1, 0, 0, 1, 1, 4, 3);
        setv(16, 0, 1, 1, 0, 0, 0, 4, 3);
        setv(17, 1, 1, 0, 0, 1, 0, 5, 3);
        setv(18, 0, 1, 0, 0, 1, 0, 5, 3);
        setv(19, 0, 1, 0, 1, 1, 0, 0, 0);
        setv(20, 1, 1, 0, 0, 1, 1, 0, 1);
        setv(21, 0, 0, 0, 0, 0, 1, 0, 1);
        setv(22, 1, 0, 0, 0, 0, 1, 0, 1);
        setv(23, 1, 1, 0, 0, 0, 1, 0, 1);
        setv(24, 1, 1, 0, 0, 0, 1, 0, 1);
        setv(25, 0, 1, 0, 0, 0, 1, 0, 1);
        setv(26, 1, 1, 0, 1, 1, 1, 0, 0);
        setv(27, 0, 1, 1, 0, 0, 0, 0, 0);
        setv(28, 1, 1, 0, 0, 1, 0, 1, 0);

        cyc(1, 0, 0, 0, 0);
        check_all("reset", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            cyc(0, vecs[i].tick, vecs[i].en, vecs[i].ack, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].irq, vecs[i].ovr,
                      vecs[i].tcnt, vecs[i].ocnt, vecs[i].tcnt, vecs[i].ocnt);
        end

        // Reset while a request is pending drops it at the same edge.
        cyc(1, 0, 1, 0, 0);
        check_all("rst_in_pend", 0, 0, 0, 0, 0, 0);

        // 100 timer ticks, each acknowledged two cycles after the request.
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk("irq_per_tick", int'(irq16), 1);
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 1, 1, 0);
            chk("irq_after_ack", int'(irq16), 0);
            cyc(0, 0, 1, 0, 0);
        end
        check_all("ticks100", 0, 0, 100, 0, 100 % 16, 0);

        // Counter width boundaries on the 4-bit instance.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 1, 0, 0);
            cyc(0, 0, 1, 1, 0);
        end
        check_all("wrap17", 0, 0, 17, 0, 1, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1, 0, 0);
            cyc(0, 0, 1, 0, 0);
        end
        check_all("sat20", 1, 1, 18, 20, 2, 15);
        cyc(0, 0, 1, 1, 0);
        check_all("ack_after_ovr", 0, 0, 18, 20, 2, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
